wfull_ctrl: RTL

WFULL_CTRL -- requirements
Module: wfull_ctrl

---
 rtl/wfull_ctrl.sv | 60 ++++++
 1 files changed

// File: rtl/wfull_ctrl.sv
// wfull_ctrl: write-domain full/almost-full/level/overflow tracking for a Gray-pointer async FIFO.
module wfull_ctrl #(
  parameter int ADDRBITS = 4,
  parameter int AF_LEVEL = (1 << ADDRBITS) - 2
) (
  input  logic                w_clk,
  input  logic                reset,
  input  logic                wen,
  input  logic [ADDRBITS:0]   wgrey,
  input  logic [ADDRBITS:0]   rgrey,
  input  logic                clr_ovf,
  output logic                f_flag,
  output logic                almost_full,
  output logic [ADDRBITS:0]   wlevel,
  output logic                overflow
);
  localparam int W = ADDRBITS + 1;
  localparam logic [W-1:0] MSB2 = {2'b11, {(W-2){1'b0}}};
  localparam logic [W-1:0] AF = W'(AF_LEVEL);
  function automatic logic [W-1:0] g2b(input logic [W-1:0] g);
    logic [W-1:0] b;
    b[W-1] = g[W-1];
    for (int i = W - 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction
  logic [W-1:0] rq1_q, rq2_q, wlevel_q, wlevel_d;
  logic [W-1:0] wbin_next, wgrey_next;
  logic         f_flag_q, f_flag_d, almost_full_q, almost_full_d, overflow_q, overflow_d, accept;
  always_comb begin
    accept        = wen & ~f_flag_q;
    wbin_next     = g2b(wgrey) + W'(accept);
    wgrey_next    = wbin_next ^ (wbin_next >> 1);
    wlevel_d      = wbin_next - g2b(rq2_q);
    f_flag_d      = wgrey_next == (rq2_q ^ MSB2);
    almost_full_d = wlevel_d >= AF;
    overflow_d    = (wen & f_flag_q) | (overflow_q & ~clr_ovf);
  end
  // rgrey is only ever consumed through the rq1/rq2 synchronizer
  always_ff @(posedge w_clk or negedge reset) begin
    if (!reset) begin
      rq1_q         <= '0;
      rq2_q         <= '0;
      wlevel_q      <= '0;
      f_flag_q      <= 1'b0;
      almost_full_q <= 1'b0;
      overflow_q    <= 1'b0;
    end else begin
      rq1_q         <= rgrey;
      rq2_q         <= rq1_q;
      wlevel_q      <= wlevel_d;
      f_flag_q      <= f_flag_d;
      almost_full_q <= almost_full_d;
      overflow_q    <= overflow_d;
    end
  end
  assign f_flag      = f_flag_q;
  assign almost_full = almost_full_q;
  assign wlevel      = wlevel_q;
  assign overflow    = overflow_q;
endmodule
